// File: rtl/mskand_hpc_sched.sv
// Round-robin scheduler sharing one pipelined HPC masked AND gadget between NREQ requesters.
// Applies the gadget's skewed input timing (rnd at t, inb at t+2, ina at t+3, out at t+4).
module mskand_hpc_sched #(
  parameter int unsigned d     = 2,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned RND_W = 2,
  parameter int unsigned TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*d-1:0]    req_a,
  input  logic [NREQ*d-1:0]    req_b,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [RND_W-1:0]     rnd_in,
  output logic [RND_W-1:0]     and_rnd,
  output logic [d-1:0]         and_inb,
  output logic [d-1:0]         and_ina,
  input  logic [d-1:0]         and_out,
  output logic                 res_valid,
  output logic [TAG_W-1:0]     res_tag,
  output logic [d-1:0]         res_data,
  output logic [2:0]           inflight,
  output logic                 idle
);

  localparam int unsigned NSTG = 4;

  logic [TAG_W-1:0] r_last;
  logic [TAG_W-1:0] w_gnt;
  logic [TAG_W-1:0] w_cand;
  logic             w_found;
  logic             w_issue;
  logic [d-1:0]     w_a;
  logic [d-1:0]     w_b;

  logic [d-1:0]     r_b1, r_b2;
  logic [d-1:0]     r_a1, r_a2, r_a3;
  logic [NSTG-1:0]  r_v;
  logic [TAG_W-1:0] r_tag [NSTG];
  logic [2:0]       r_inflight;

  // Upward search from the requester after the last grant, with wrap.
  always_comb begin
    w_gnt   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_cand = TAG_W'((32'(r_last) + i) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_issue   = en & rnd_valid & w_found;
  assign req_ready = w_issue ? (NREQ'(1) << w_gnt) : '0;
  assign rnd_ready = w_issue;
  assign and_rnd   = w_issue ? rnd_in : '0;

  // Bubbles capture zero shares so stale operands never reach the gadget.
  assign w_a = w_issue ? req_a[w_gnt*d +: d] : '0;
  assign w_b = w_issue ? req_b[w_gnt*d +: d] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= TAG_W'(NREQ - 1);
      r_b1   <= '0;
      r_b2   <= '0;
      r_a1   <= '0;
      r_a2   <= '0;
      r_a3   <= '0;
      r_v    <= '0;
      for (int unsigned s = 0; s < NSTG; s++) r_tag[s] <= '0;
    end else begin
      if (w_issue) r_last <= w_gnt;
      r_b1     <= w_b;
      r_b2     <= r_b1;
      r_a1     <= w_a;
      r_a2     <= r_a1;
      r_a3     <= r_a2;
      r_v      <= {r_v[NSTG-2:0], w_issue};
      r_tag[0] <= w_issue ? w_gnt : '0;
      for (int unsigned s = 1; s < NSTG; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  // Occupancy: issue adds one, a presented result removes one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, r_v[NSTG-1]})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign and_inb   = r_b2;
  assign and_ina   = r_a3;
  assign res_valid = r_v[NSTG-1];
  assign res_tag   = r_tag[NSTG-1];
  assign res_data  = and_out;
  assign inflight  = r_inflight;
  assign idle      = (r_inflight == 3'd0) & ~w_issue;

endmodule
